// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin debounce, credit, vend and change return; optional refund via COIN_REFUND_EN
module coin_acceptor #(
    parameter int PRICE_SINGLE = 100,
    parameter int PRICE_DOUBLE = 150,
    parameter int CREDIT_W     = 8,
    parameter int DEBOUNCE_CYC = 4,
    parameter int CHANGE_UNIT  = 25
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_25,
    input  logic                coin_50,
    input  logic                coin_100,
    input  logic                double_sel,
    input  logic                refund_req,
    input  logic                wash_done,
    output logic                coin_in,
    output logic                double_wash,
    output logic [CREDIT_W-1:0] credit,
    output logic                change_pulse,
    output logic                busy
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int SUM_W = CREDIT_W + 2;

    localparam logic [CNT_W-1:0]    CNT_MAX    = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0]    CNT_FIRE   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;
    localparam logic [CREDIT_W-1:0] P_SINGLE   = CREDIT_W'(PRICE_SINGLE);
    localparam logic [CREDIT_W-1:0] P_DOUBLE   = CREDIT_W'(PRICE_DOUBLE);
    localparam logic [CREDIT_W-1:0] UNIT       = CREDIT_W'(CHANGE_UNIT);

    typedef enum logic [2:0] {
        ST_IDLE, ST_COLLECT, ST_VEND, ST_CHANGE, ST_WASH
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                double_wash_q, double_wash_d;
    logic                vended_q, vended_d;
    logic                phase_q, phase_d;

    logic [2:0]          raw;
    logic [2:0]          sync1_q, sync2_q;
    logic [CNT_W-1:0]    cnt_q [3];
    logic [2:0]          coin_ev;

    logic [SUM_W-1:0]    coin_sum;
    logic [SUM_W-1:0]    credit_acc;
    logic [CREDIT_W-1:0] credit_sat;
    logic [CREDIT_W-1:0] price;
    logic [CREDIT_W-1:0] remainder;

`ifndef COIN_REFUND_EN
    logic unused_refund;
    assign unused_refund = refund_req;
`endif

    // bit order of raw/coin_ev: 0 = 25c, 1 = 50c, 2 = 100c
    assign raw = {coin_100, coin_50, coin_25};

    // synchronize each coin line and count consecutive high samples, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 3; i++) begin
                if (!sync2_q[i]) cnt_q[i] <= '0;
                else if (cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // a line fires once, on the sample that brings its run up to DEBOUNCE_CYC; sum and saturate
    always_comb begin
        for (int i = 0; i < 3; i++) coin_ev[i] = sync2_q[i] && (cnt_q[i] == CNT_FIRE);
        coin_sum = '0;
        if (coin_ev[0]) coin_sum = coin_sum + SUM_W'(25);
        if (coin_ev[1]) coin_sum = coin_sum + SUM_W'(50);
        if (coin_ev[2]) coin_sum = coin_sum + SUM_W'(100);
        credit_acc = SUM_W'(credit_q) + coin_sum;
        credit_sat = (credit_acc > SUM_W'(CREDIT_MAX)) ? CREDIT_MAX : credit_acc[CREDIT_W-1:0];
        price      = double_sel ? P_DOUBLE : P_SINGLE;
        remainder  = (credit_q >= price) ? credit_q - price : '0;
    end

    // state register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            double_wash_q <= 1'b0;
            vended_q      <= 1'b0;
            phase_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            double_wash_q <= double_wash_d;
            vended_q      <= vended_d;
            phase_q       <= phase_d;
        end
    end

    // next state: vend beats refund; change alternates pulse/gap and forfeits a sub-unit remainder
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        double_wash_d = double_wash_q;
        vended_d      = vended_q;
        phase_d       = phase_q;
        unique case (state_q)
            ST_IDLE: begin
                credit_d = '0;
                vended_d = 1'b0;
                phase_d  = 1'b0;
                if (|coin_ev) begin
                    credit_d = credit_sat;
                    state_d  = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                credit_d = credit_sat;
                if (credit_q >= price) begin
                    state_d = ST_VEND;
`ifdef COIN_REFUND_EN
                end else if (refund_req) begin
                    state_d  = ST_CHANGE;
                    vended_d = 1'b0;
                    phase_d  = 1'b0;
`endif
                end
            end
            ST_VEND: begin
                credit_d      = remainder;
                double_wash_d = double_sel;
                vended_d      = 1'b1;
                phase_d       = 1'b0;
                state_d       = (remainder != '0) ? ST_CHANGE : ST_WASH;
            end
            ST_CHANGE: begin
                if (phase_q) begin
                    phase_d = 1'b0;
                end else if (credit_q >= UNIT) begin
                    credit_d = credit_q - UNIT;
                    phase_d  = 1'b1;
                end else begin
                    credit_d = '0;
                    state_d  = vended_q ? ST_WASH : ST_IDLE;
                end
            end
            ST_WASH: begin
                if (wash_done) begin
                    double_wash_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        coin_in      = (state_q == ST_VEND);
        busy         = (state_q == ST_VEND) || (state_q == ST_CHANGE) || (state_q == ST_WASH);
        change_pulse = (state_q == ST_CHANGE) && !phase_q && (credit_q >= UNIT);
        credit       = credit_q;
        double_wash  = double_wash_q;
    end
endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - self-checking bench for coin_acceptor against a behavioural payment model
module tb_coin_acceptor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_25 = 1'b0, coin_50 = 1'b0, coin_100 = 1'b0;
    logic       double_sel = 1'b0, refund_req = 1'b0, wash_done = 1'b0;
    logic       coin_in, double_wash, change_pulse, busy;
    logic [7:0] credit;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    coin_acceptor dut (
        .clk(clk), .rst(rst),
        .coin_25(coin_25), .coin_50(coin_50), .coin_100(coin_100),
        .double_sel(double_sel), .refund_req(refund_req), .wash_done(wash_done),
        .coin_in(coin_in), .double_wash(double_wash), .credit(credit),
        .change_pulse(change_pulse), .busy(busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_COLLECT = 1, M_VEND = 2, M_CHANGE = 3, M_WASH = 4;
    localparam int DEB = 4;
`ifdef COIN_REFUND_EN
    localparam bit REFUND = 1'b1;
`else
    localparam bit REFUND = 1'b0;
`endif

    int m_mode, m_credit, m_dw, m_vended;
    int ch_v, ch_n, ch_t;
    int run [3];
    bit d1 [3], d2 [3];
    int coin_val [3] = '{25, 50, 100};

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_credit = 0; m_dw = 0; m_vended = 0;
        ch_v = 0; ch_n = 0; ch_t = 0;
        for (int i = 0; i < 3; i++) begin run[i] = 0; d1[i] = 0; d2[i] = 0; end
    endtask

    task automatic start_change(input int v);
        ch_v = v; ch_n = v / 25; ch_t = 0;
        m_credit = v; m_mode = M_CHANGE;
    endtask

    always @(posedge clk) begin : model
        bit ev [3];
        bit raw [3];
        int coins, price, c_old, rem;
        raw[0] = coin_25; raw[1] = coin_50; raw[2] = coin_100;
        if (rst) begin
            model_reset();
        end else begin
            // a run reaching DEB samples is accepted two edges later (synchronizer delay)
            coins = 0;
            for (int i = 0; i < 3; i++) begin
                ev[i] = d2[i];
                d2[i] = d1[i];
                run[i] = raw[i] ? run[i] + 1 : 0;
                d1[i] = (run[i] == DEB);
                if (ev[i]) coins += coin_val[i];
            end
            price = double_sel ? 150 : 100;
            case (m_mode)
                M_IDLE: begin
                    m_vended = 0;
                    if (coins > 0) begin m_credit = sat(coins); m_mode = M_COLLECT; end
                    else m_credit = 0;
                end
                M_COLLECT: begin
                    c_old = m_credit;
                    m_credit = sat(m_credit + coins);
                    if (c_old >= price) m_mode = M_VEND;
                    else if (REFUND && refund_req) begin m_vended = 0; start_change(m_credit); end
                end
                M_VEND: begin
                    rem = (m_credit >= price) ? m_credit - price : 0;
                    m_dw = double_sel;
                    m_vended = 1;
                    if (rem > 0) start_change(rem);
                    else begin m_credit = 0; m_mode = M_WASH; end
                end
                M_CHANGE: begin
                    if (ch_t == 2 * ch_n) begin
                        m_credit = 0;
                        m_mode = m_vended ? M_WASH : M_IDLE;
                    end else begin
                        ch_t++;
                        m_credit = ch_v - 25 * ((ch_t + 1) / 2);
                    end
                end
                default: begin
                    if (wash_done) begin m_dw = 0; m_mode = M_IDLE; end
                end
            endcase
        end
    end

    // compare every cycle, 1 time unit after the active edge
    always @(posedge clk) begin
        #1;
        check("cyc_coin_in", coin_in, (m_mode == M_VEND) ? 1 : 0);
        check("cyc_busy", busy, (m_mode == M_VEND || m_mode == M_CHANGE || m_mode == M_WASH) ? 1 : 0);
        check("cyc_credit", credit, m_credit);
        check("cyc_double_wash", double_wash, m_dw);
        check("cyc_change_pulse", change_pulse,
              (m_mode == M_CHANGE && ch_t < 2 * ch_n && (ch_t % 2) == 0) ? 1 : 0);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        tick(3);
        check("rst_credit", credit, 0);
        check("rst_busy", busy, 0);
        check("rst_coin_in", coin_in, 0);
        rst = 1'b0;
        tick(2);

        // single wash from one 100c coin
        coin_100 = 1'b1;
        tick(6);
        check("t1_credit100", credit, 100);
        check("t1_no_vend_yet", coin_in, 0);
        tick(1);
        check("t1_coin_in", coin_in, 1);
        check("t1_busy_vend", busy, 1);
        tick(1);
        check("t1_coin_in_once", coin_in, 0);
        check("t1_credit0", credit, 0);
        check("t1_busy_wash", busy, 1);
        tick(2);
        coin_100 = 1'b0;
        tick(2);
        wash_done = 1'b1;
        tick(1);
        check("t1_idle_busy", busy, 0);
        wash_done = 1'b0;

        // short glitch never reaches the debounce threshold
        coin_25 = 1'b1;
        tick(3);
        coin_25 = 1'b0;
        tick(8);
        check("glitch25_credit", credit, 0);

        // double wash from 50 + 100 in two events
        double_sel = 1'b1;
        coin_50 = 1'b1;
        tick(6);
        check("t2_credit50", credit, 50);
        coin_50 = 1'b0;
        tick(2);
        coin_100 = 1'b1;
        tick(6);
        check("t2_credit150", credit, 150);
        coin_100 = 1'b0;
        tick(1);
        check("t2_coin_in", coin_in, 1);
        tick(1);
        check("t2_double_wash", double_wash, 1);
        check("t2_credit0", credit, 0);
        check("t2_no_change", change_pulse, 0);
        tick(2);
        double_sel = 1'b0;
        tick(1);
        check("t2_dw_held", double_wash, 1);
        wash_done = 1'b1;
        tick(1);
        check("t2_dw_cleared", double_wash, 0);
        wash_done = 1'b0;

        // simultaneous 100 + 50, single wash, 50 change
        coin_100 = 1'b1; coin_50 = 1'b1;
        tick(6);
        check("t3_credit150", credit, 150);
        coin_100 = 1'b0; coin_50 = 1'b0;
        tick(1);
        check("t3_coin_in", coin_in, 1);
        tick(1);
        check("t3_pulse1", change_pulse, 1);
        check("t3_credit50", credit, 50);
        tick(1);
        check("t3_gap1", change_pulse, 0);
        tick(1);
        check("t3_pulse2", change_pulse, 1);
        check("t3_credit25", credit, 25);
        tick(1);
        check("t3_credit0", credit, 0);
        tick(2);
        check("t3_wash_busy", busy, 1);
        // coin held through WASH and its return to IDLE must not add credit
        coin_50 = 1'b1;
        tick(8);
        wash_done = 1'b1;
        tick(1);
        wash_done = 1'b0;
        tick(6);
        check("wash_glitch_credit", credit, 0);
        check("wash_glitch_busy", busy, 0);
        coin_50 = 1'b0;
        tick(2);

        // refund request with 50c credit
        coin_50 = 1'b1;
        tick(6);
        check("t4_credit50", credit, 50);
        coin_50 = 1'b0;
        tick(1);
        refund_req = 1'b1;
        tick(1);
`ifdef COIN_REFUND_EN
        check("t4_refund_pulse", change_pulse, 1);
        check("t4_refund_busy", busy, 1);
`else
        check("t4_ignored_credit", credit, 50);
        check("t4_ignored_busy", busy, 0);
`endif
        refund_req = 1'b0;
        tick(5);
`ifdef COIN_REFUND_EN
        check("t4_refund_idle", busy, 0);
        check("t4_refund_credit", credit, 0);
`else
        check("t4_kept_credit", credit, 50);
`endif
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t4_rst_credit", credit, 0);
        tick(2);

        // reset during CHANGE with 75c outstanding
        coin_25 = 1'b1; coin_50 = 1'b1; coin_100 = 1'b1;
        tick(6);
        check("t5_credit175", credit, 175);
        coin_25 = 1'b0; coin_50 = 1'b0; coin_100 = 1'b0;
        tick(2);
        check("t5_credit75", credit, 75);
        rst = 1'b1;
        tick(1);
        check("t5_rst_credit", credit, 0);
        check("t5_rst_pulse", change_pulse, 0);
        check("t5_rst_busy", busy, 0);
        rst = 1'b0;
        tick(2);

        // saturation at 255, double wash, 105 remainder: 4 pulses, 5c forfeited
        double_sel = 1'b1;
        coin_100 = 1'b1;
        tick(6);
        check("t6_credit100", credit, 100);
        coin_100 = 1'b0;
        tick(2);
        coin_25 = 1'b1; coin_50 = 1'b1; coin_100 = 1'b1;
        tick(6);
        check("t6_saturated", credit, 255);
        coin_25 = 1'b0; coin_50 = 1'b0; coin_100 = 1'b0;
        tick(1);
        check("t6_coin_in", coin_in, 1);
        tick(1);
        check("t6_credit105", credit, 105);
        tick(8);
        check("t6_forfeit5", credit, 5);
        wash_done = 1'b1;
        double_sel = 1'b0;
        tick(1);
        check("t6_wash_busy", busy, 1);
        check("t6_wash_credit", credit, 0);
        tick(1);
        check("t6_early_done_idle", busy, 0);
        wash_done = 1'b0;
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Payment front end for the washing-machine controller; sits directly upstream of the wash FSM/timer top level. It debounces three coin-mechanism lines, accumulates credit, and vends when credit reaches the wash price. A vend raises a one-cycle `coin_in` pulse with a held `double_wash` level into the wash FSM. It then returns change and blocks new payment until the wash FSM reports `wash_done`.

## Interface
- `PRICE_SINGLE`, 100: price of a single wash, in cents.
- `PRICE_DOUBLE`, 150: price of a double wash, in cents.
- `CREDIT_W`, 8: credit register width; both prices must be < 2^CREDIT_W.
- `DEBOUNCE_CYC`, 4: consecutive high samples required to accept a coin line.
- `CHANGE_UNIT`, 25: value returned per `change_pulse`.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: synchronous, active-high reset.
- `coin_25`, `coin_50`, `coin_100`  in  1 each: raw coin-mechanism levels, asynchronous to `clk`.
- `double_sel`  in  1: customer selects a double wash.
- `refund_req`  in  1: customer requests a refund (level).
- `wash_done`  in  1: from the wash FSM; high means the wash is finished.
- `coin_in`  out  1: one-cycle vend pulse to the wash FSM.
- `double_wash`  out  1: wash mode latched at vend, held through the wash.
- `credit`  out  CREDIT_W: current credit in cents.
- `change_pulse`  out  1: one pulse per CHANGE_UNIT returned.
- `busy`  out  1: high in VEND, CHANGE and WASH states; coins are not accepted.

## Operation
- Each coin line has a 2-flop synchronizer followed by a saturating stable-high counter.
- A coin event fires once, when the counter first reaches DEBOUNCE_CYC. The line must return low before that coin line can produce another event.
- Coin events in the same cycle are summed. Credit saturates at 2^CREDIT_W-1.
- Coin events outside IDLE/COLLECT are discarded. Debounce still runs, so a held line does not fire on state return.
- Price is `double_sel ? PRICE_DOUBLE : PRICE_SINGLE`, evaluated every cycle.
- States:
  - IDLE: `credit`=0. Any coin event adds credit and moves to COLLECT.
  - COLLECT: accumulate credit. If credit >= price → VEND; this takes priority over refund. If `refund_req` is high → CHANGE with no vend.
  - VEND (1 cycle): `coin_in`=1; `double_wash` <= `double_sel`; credit -= price. Next state is CHANGE if the remainder > 0, else WASH.
  - CHANGE: while credit >= CHANGE_UNIT, `change_pulse` is high for 1 cycle and low for 1 cycle, with credit -= CHANGE_UNIT on each high cycle. A remainder < CHANGE_UNIT is cleared (forfeited). Exit to WASH if a vend occurred, else IDLE.
  - WASH: waits for `wash_done`=1. On that sample: `double_wash` <= 0 and state → IDLE.
- Reset mid-operation: the state returns to IDLE, credit is lost, and no change is paid.

## Timing
- Reset values:
  - `coin_in`=0, `double_wash`=0, `credit`=0, `change_pulse`=0, `busy`=0.
  - Debounce counters and synchronizers are cleared; state is IDLE.
- Coin latency: a line sampled high from edge e0 is reflected in `credit` after edge e0+1+DEBOUNCE_CYC (2 synchronizer edges plus DEBOUNCE_CYC−1 counter edges).
- The VEND state is entered on the edge after `credit` >= price is visible. `coin_in` is high for exactly that cycle.
- `busy` rises in the same cycle as `coin_in` (and on CHANGE entry for a refund). It falls on the edge where WASH/CHANGE → IDLE.
- `change_pulse` spacing is 2 cycles; the first pulse appears in the first CHANGE cycle.
- A `wash_done` that is already high on WASH entry exits after 1 WASH cycle.

## Configuration
- `COIN_REFUND_EN` defined: `refund_req` is honoured in COLLECT as described above.
- `COIN_REFUND_EN` undefined: `refund_req` is ignored and credit stays in COLLECT until vend. CHANGE is reachable only after a vend.

## Test plan
- Defaults; `coin_100` high for 10 cycles, `double_sel`=0:
  - `credit`=100 visible 6 cycles after the line rises.
  - One `coin_in` pulse on the next cycle; `credit`=0; state WASH; `busy`=1.
  - `wash_done`=1 → IDLE; `busy`=0.
- `coin_50` then `coin_100` (each a separate clean debounced pulse), `double_sel`=1: vend with `double_wash`=1 and credit 150→0; no `change_pulse`.
- `coin_100` + `coin_50` simultaneously, `double_sel`=0: credit goes 0→150 in one step; vend; remainder 50 → 2 `change_pulse`s 2 cycles apart; `credit`=0, then WASH.
- Glitches: `coin_25` high for 3 cycles → no credit; `coin_50` high during WASH → credit stays 0 after return to IDLE.
- With `COIN_REFUND_EN`: `coin_50` then `refund_req`=1 → 2 `change_pulse`s, no `coin_in`, back to IDLE. Without the macro: credit stays at 50.
- `rst`=1 in CHANGE with credit 75 → next cycle: IDLE, `credit`=0, `change_pulse`=0, `busy`=0.
